// File: rtl/clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_pkg
// Shared definitions for the multi-channel clock divider:
//   DEFAULT_DIV_C  default half-period divisor loaded at reset
//   MAX_CHANNELS   largest supported channel count
//   MAX_WIDTH      widest divisor the saturation helper handles
//   chan_state_e   per-channel operating state (idle / running)
//   sat_div()      maps a divisor of 0 to 1; a zero divisor is never stored
// -----------------------------------------------------------------------------
package clock_divider_pkg;

   localparam int unsigned DEFAULT_DIV_C = 5_000_000;
   localparam int          MAX_CHANNELS  = 16;
   localparam int          MAX_WIDTH     = 64;

   // The state is simply the sampled enable, so the encoding mirrors it.
   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } chan_state_e;

   function automatic logic [MAX_WIDTH-1:0] sat_div(input logic [MAX_WIDTH-1:0] value);
      return (value == '0) ? MAX_WIDTH'(1) : value;
   endfunction

endpackage

// File: rtl/divider_channel.sv
// -----------------------------------------------------------------------------
// divider_channel
// One divider channel: half-period counter, active divisor, pending divisor.
// Produces a 50% duty square wave of period 2*D and a one-cycle tick in the
// first cycle the square wave is high. A newly written divisor is held as
// pending and only swapped in at a terminal count (or at once while idle), so
// no half-period is ever cut short.
//
// Ports:
//   clock_in     sole clock, rising edge
//   reset        synchronous, active-high
//   enable       run enable for this channel
//   wr           write strobe for this channel's divisor
//   wr_value     new half-period in clock_in cycles (0 is stored as 1)
//   clock_out    divided clock (registered)
//   tick         one-cycle pulse coincident with clock_out's first high cycle
//   div_pending  a written divisor has not yet been applied
// -----------------------------------------------------------------------------
module divider_channel
   import clock_divider_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_C)
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_value,
   output logic             clock_out,
   output logic             tick,
   output logic             div_pending
);

   localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(sat_div(MAX_WIDTH'(DEFAULT_DIV)));

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_active;
   logic [WIDTH-1:0] div_next;
   logic             pending;
   logic [WIDTH-1:0] wr_sat;
   logic             terminal;
   chan_state_e      state;

   assign state    = chan_state_e'(enable);
   assign wr_sat   = WIDTH'(sat_div(MAX_WIDTH'(wr_value)));
   // div_active is never 0, so D-1 never underflows and cnt stays below D.
   assign terminal = (cnt == div_active - WIDTH'(1));

   // NOTE: all state here is sequential and uses non-blocking assignments, so
   // every right-hand side sees the pre-edge value (terminal count uses the
   // old pending/div_next even when a write lands on the same edge).
   always_ff @(posedge clock_in) begin
      if (reset) begin
         cnt        <= '0;
         div_active <= RESET_DIV;
         div_next   <= RESET_DIV;
         pending    <= 1'b0;
         clock_out  <= 1'b0;
         tick       <= 1'b0;
      end else begin
         tick <= 1'b0;
         case (state)
            CH_IDLE: begin
               cnt       <= '0;
               clock_out <= 1'b0;
               if (pending) begin
                  div_active <= div_next;
                  pending    <= 1'b0;
               end
            end
            CH_RUN: begin
               if (terminal) begin
                  cnt       <= '0;
                  clock_out <= ~clock_out;
                  // Rising transition: tick shares clock_out's first high cycle.
                  tick      <= ~clock_out;
                  if (pending) begin
                     div_active <= div_next;
                     pending    <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
            default: begin
               cnt       <= '0;
               clock_out <= 1'b0;
            end
         endcase
         // NOTE: this later non-blocking assignment overrides the pending clear
         // above, so a write coinciding with an application stays pending.
         if (wr) begin
            div_next <= wr_sat;
            pending  <= 1'b1;
         end
      end
   end

   assign div_pending = pending;

endmodule

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
// CHANNELS independent programmable clock dividers driven from one clock.
// The top level only decodes the shared divisor write port into per-channel
// strobes; each channel is a divider_channel instance.
//
// Parameters:
//   CHANNELS     number of channels (1..16)
//   WIDTH        divisor / counter width
//   DEFAULT_DIV  half-period divisor loaded at reset (0 is stored as 1)
//
// Ports:
//   clock_in     sole clock, rising edge
//   reset        synchronous, active-high; overrides everything
//   enable       per-channel run enable
//   div_wr       divisor write strobe, one cycle per write
//   div_sel      target channel; values >= CHANNELS are ignored
//   div_value    new half-period in clock_in cycles
//   clock_out    divided clocks, period 2*D, 50% duty
//   tick         one-cycle pulse in the first high cycle of clock_out
//   div_pending  written divisor not yet applied
// -----------------------------------------------------------------------------
module multi_clock_divider
   import clock_divider_pkg::*;
#(
   parameter  int          CHANNELS    = 4,
   parameter  int          WIDTH       = 32,
   parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
   localparam int          SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock_in,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enable,
   input  logic                div_wr,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [WIDTH-1:0]    div_value,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] div_pending
);

   localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);

   logic [CHANNELS-1:0] wr_strobe;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      // A select value with no matching channel simply strobes nothing.
      assign wr_strobe[i] = div_wr && (div_sel == SEL_W'(i));

      divider_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV_W)
      ) u_channel (
         .clock_in    (clock_in),
         .reset       (reset),
         .enable      (enable[i]),
         .wr          (wr_strobe[i]),
         .wr_value    (div_value),
         .clock_out   (clock_out[i]),
         .tick        (tick[i]),
         .div_pending (div_pending[i])
      );
   end

endmodule
